// File: rtl/aes_pkg.sv
// Shared definitions for the AES operand loader: FSM states, key-size codes
// and the Nk/Nr constants derived from them.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_BLOCK,
        ISSUE,
        WAIT_DONE
    } state_t;

    // Codes are {s1,s2} as presented on the select pins.
    typedef enum logic [1:0] {
        KEY_128 = 2'b00,
        KEY_256 = 2'b01,
        KEY_192 = 2'b10,
        KEY_BAD = 2'b11
    } key_size_t;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [4:0] BLOCK_LAST_IDX = 5'd15;

    function automatic logic [3:0] nk_of(key_size_t ks);
        case (ks)
            KEY_192: return NK_192;
            KEY_256: return NK_256;
            default: return NK_128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_size_t ks);
        case (ks)
            KEY_192: return NR_192;
            KEY_256: return NR_256;
            default: return NR_128;
        endcase
    endfunction

    // Index of the final key byte: 4*Nk bytes, counted from zero.
    function automatic logic [4:0] key_last_idx(key_size_t ks);
        logic [5:0] nbytes;
        nbytes = {nk_of(ks), 2'b00};
        return 5'(nbytes - 6'd1);
    endfunction

endpackage

// File: rtl/aes_byte_shreg.sv
// Byte-wide MSB-first load register: byte k lands at data[WIDTH-1-8k -: 8].
// The first byte of an operand wipes any stale bytes from an earlier load.
module aes_byte_shreg #(
    parameter int WIDTH = 128,
    localparam int IDX_W = $clog2(WIDTH / 8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             first,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data <= '0;
        end else if (load) begin
            if (first) begin
                data <= {byte_in, {(WIDTH - 8){1'b0}}};
            end else begin
                data[WIDTH - 1 - 8 * int'(idx) -: 8] <= byte_in;
            end
        end
    end

endmodule

// File: rtl/aes_operand_loader.sv
// Collects key and block bytes for the AES core, publishes them atomically on
// entry to ISSUE, pulses start and then waits (bounded) for the core's done.
module aes_operand_loader
    import aes_pkg::*;
#(
    parameter int DONE_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s1,
    input  logic         s2,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    input  logic         clear,
    input  logic         done,
    output logic [255:0] key_out,
    output logic [127:0] block_out,
    output logic [3:0]   nk,
    output logic [3:0]   nr,
    output logic         start,
    output logic         busy,
    output logic         err
);

    localparam int TW = $clog2(DONE_TIMEOUT) + 1;

    state_t         state;
    state_t         state_next;
    key_size_t      size_q;
    key_size_t      size_in;
    logic [4:0]     count;
    logic [TW-1:0]  timer;
    logic [255:0]   key_shadow;
    logic [127:0]   block_shadow;
    logic           accept;
    logic           key_last;
    logic           block_last;
    logic           timeout;
    logic           err_next;
    logic           key_load;
    logic           key_first;
    logic           block_load;

    assign size_in    = key_size_t'({s1, s2});
    assign byte_ready = (state == IDLE) || (state == LOAD_KEY) || (state == LOAD_BLOCK);
    assign accept     = byte_valid && byte_ready && !clear;
    assign key_last   = (count == key_last_idx(size_q));
    assign block_last = (count == BLOCK_LAST_IDX);
    assign timeout    = (timer == TW'(DONE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            err   <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        busy       = 1'b0;
        err_next   = 1'b0;
        key_load   = 1'b0;
        key_first  = 1'b0;
        block_load = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (size_in == KEY_BAD) begin
                        err_next = 1'b1;
                    end else begin
                        key_load   = 1'b1;
                        key_first  = 1'b1;
                        state_next = LOAD_KEY;
                    end
                end
            end
            LOAD_KEY: begin
                if (accept) begin
                    key_load = 1'b1;
                    if (key_last) state_next = LOAD_BLOCK;
                end
            end
            LOAD_BLOCK: begin
                if (accept) begin
                    block_load = 1'b1;
                    if (block_last) state_next = ISSUE;
                end
            end
            ISSUE: begin
                start      = 1'b1;
                busy       = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                busy = 1'b1;
                if (done) begin
                    state_next = IDLE;
                end else if (timeout) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
            err_next   = 1'b0;
        end
    end

    // Counter, timer and the published operand registers; clear leaves the
    // published values untouched so the core keeps a consistent view.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            timer     <= '0;
            size_q    <= KEY_128;
            key_out   <= '0;
            block_out <= '0;
            nk        <= NK_128;
            nr        <= NR_128;
        end else if (clear) begin
            count <= '0;
            timer <= '0;
        end else begin
            if (state == IDLE && key_load) begin
                size_q <= size_in;
                count  <= 5'd1;
            end else if (state == LOAD_KEY && accept) begin
                count <= key_last ? 5'd0 : count + 5'd1;
            end else if (state == LOAD_BLOCK && accept) begin
                count <= block_last ? 5'd0 : count + 5'd1;
            end
            timer <= (state == WAIT_DONE) ? timer + TW'(1) : '0;
            if (state == LOAD_BLOCK && accept && block_last) begin
                key_out   <= key_shadow;
                block_out <= {block_shadow[127:8], byte_in};
                nk        <= nk_of(size_q);
                nr        <= nr_of(size_q);
            end
        end
    end

    aes_byte_shreg #(.WIDTH(256)) u_key_shadow (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .load    (key_load),
        .first   (key_first),
        .idx     (count),
        .byte_in (byte_in),
        .data    (key_shadow)
    );

    aes_byte_shreg #(.WIDTH(128)) u_block_shadow (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .load    (block_load),
        .first   (1'b0),
        .idx     (count[3:0]),
        .byte_in (byte_in),
        .data    (block_shadow)
    );

endmodule

// File: tb/tb_aes_operand_loader.sv
// Directed and randomized checks of aes_operand_loader against a byte-stream
// reference model that rebuilds the expected operands by concatenation.
module tb_aes_operand_loader;

    logic         clk;
    logic         reset;
    logic         s1;
    logic         s2;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         clear;
    logic         done;
    logic [255:0] key_out;
    logic [127:0] block_out;
    logic [3:0]   nk;
    logic [3:0]   nr;
    logic         start;
    logic         busy;
    logic         err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]   key_bytes [32];
    logic [7:0]   block_bytes [16];
    logic [255:0] exp_key;
    logic [127:0] exp_block;
    logic [3:0]   exp_nk;
    logic [3:0]   exp_nr;
    int           accepted;
    bit           start_early;

    aes_operand_loader #(.DONE_TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .s1         (s1),
        .s2         (s2),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .clear      (clear),
        .done       (done),
        .key_out    (key_out),
        .block_out  (block_out),
        .nk         (nk),
        .nr         (nr),
        .start      (start),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] observed,
                               input logic [255:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 32; i++) key_bytes[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) block_bytes[i] = 8'($urandom);
    endtask

    // Reference: operands are the accepted byte stream read first-byte-first,
    // the key left-justified in 256 bits.
    task automatic modelIssue(input logic [1:0] sz);
        int nbytes;
        logic [255:0] acc;
        logic [127:0] bacc;
        case (sz)
            2'b00:   begin exp_nk = 4'd4; exp_nr = 4'd10; end
            2'b10:   begin exp_nk = 4'd6; exp_nr = 4'd12; end
            default: begin exp_nk = 4'd8; exp_nr = 4'd14; end
        endcase
        nbytes = 4 * int'(exp_nk);
        acc = '0;
        for (int i = 0; i < nbytes; i++) acc = (acc << 8) | 256'(key_bytes[i]);
        exp_key = acc << (256 - 8 * nbytes);
        bacc = '0;
        for (int i = 0; i < 16; i++) bacc = (bacc << 8) | 128'(block_bytes[i]);
        exp_block = bacc;
    endtask

    task automatic applyStimulus(input logic [1:0] sz, input bit gaps);
        int nkey;
        int total;
        int idx;
        int guard;
        bit mid_done;
        nkey = (sz == 2'b00) ? 16 : (sz == 2'b10) ? 24 : 32;
        total = nkey + 16;
        idx = 0;
        guard = 0;
        accepted = 0;
        start_early = 1'b0;
        mid_done = 1'b0;
        s1 = sz[1];
        s2 = sz[0];
        while (idx < total && guard < 4 * total) begin
            guard++;
            if (start === 1'b1) start_early = 1'b1;
            if (idx == nkey && !mid_done) begin
                mid_done = 1'b1;
                checkOutput("key_held_during_load", key_out, exp_key);
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                byte_valid = 1'b0;
                tick();
            end else begin
                byte_in = (idx < nkey) ? key_bytes[idx] : block_bytes[idx - nkey];
                byte_valid = 1'b1;
                if (byte_ready === 1'b1) begin
                    accepted++;
                    idx++;
                end
                tick();
                if (idx >= 1) begin
                    s1 = 1'($urandom_range(0, 1));
                    s2 = 1'($urandom_range(0, 1));
                end
            end
        end
        byte_valid = 1'b0;
        checkOutput("load_complete", 256'(idx), 256'(total));
    endtask

    task automatic checkIssue(input logic [1:0] sz);
        modelIssue(sz);
        checkOutput("no_early_start", 256'(start_early), 256'(0));
        checkOutput("start_in_issue", 256'(start), 256'(1));
        checkOutput("busy_in_issue", 256'(busy), 256'(1));
        checkOutput("ready_low_in_issue", 256'(byte_ready), 256'(0));
        checkOutput("accepted_bytes", 256'(accepted), 256'(4 * int'(exp_nk) + 16));
        checkOutput("key_out", key_out, exp_key);
        checkOutput("block_out", 256'(block_out), 256'(exp_block));
        checkOutput("nk", 256'(nk), 256'(exp_nk));
        checkOutput("nr", 256'(nr), 256'(exp_nr));
    endtask

    task automatic waitDone(input int d);
        bit busy_ok;
        busy_ok = 1'b1;
        tick();
        for (int j = 0; j < d; j++) begin
            if (busy !== 1'b1 || start !== 1'b0) busy_ok = 1'b0;
            tick();
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        checkOutput("busy_until_done", 256'(busy_ok), 256'(1));
        done = 1'b1;
        tick();
        done = 1'b0;
        checkOutput("idle_after_done", 256'(busy), 256'(0));
        checkOutput("no_err_on_done", 256'(err), 256'(0));
        checkOutput("ready_after_done", 256'(byte_ready), 256'(1));
        checkOutput("key_held_after_done", key_out, exp_key);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_key"}, key_out, 256'(0));
        checkOutput({tag, "_block"}, 256'(block_out), 256'(0));
        checkOutput({tag, "_nk"}, 256'(nk), 256'(4));
        checkOutput({tag, "_nr"}, 256'(nr), 256'(10));
        checkOutput({tag, "_start"}, 256'(start), 256'(0));
        checkOutput({tag, "_busy"}, 256'(busy), 256'(0));
        checkOutput({tag, "_err"}, 256'(err), 256'(0));
        checkOutput({tag, "_ready"}, 256'(byte_ready), 256'(1));
    endtask

    initial begin
        bit busy_ok;
        logic [1:0] sz;
        reset = 1'b1;
        s1 = 1'b0;
        s2 = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        clear = 1'b0;
        done = 1'b0;
        exp_key = '0;
        exp_block = '0;
        exp_nk = 4'd4;
        exp_nr = 4'd10;
        tick();
        tick();
        checkResetValues("reset");
        reset = 1'b0;

        // done outside WAIT_DONE has no effect
        done = 1'b1;
        tick();
        done = 1'b0;
        checkOutput("done_in_idle_busy", 256'(busy), 256'(0));
        checkOutput("done_in_idle_err", 256'(err), 256'(0));

        // invalid key size on the first byte
        s1 = 1'b1;
        s2 = 1'b1;
        byte_in = 8'hA5;
        byte_valid = 1'b1;
        checkOutput("ready_before_bad_size", 256'(byte_ready), 256'(1));
        tick();
        byte_valid = 1'b0;
        checkOutput("bad_size_err", 256'(err), 256'(1));
        checkOutput("bad_size_ready", 256'(byte_ready), 256'(1));
        checkOutput("bad_size_busy", 256'(busy), 256'(0));
        checkOutput("bad_size_key", key_out, 256'(0));
        checkOutput("bad_size_nk", 256'(nk), 256'(4));
        tick();
        checkOutput("bad_size_err_pulse", 256'(err), 256'(0));

        // 128-bit directed load
        for (int i = 0; i < 32; i++) key_bytes[i] = 8'(i);
        for (int i = 0; i < 16; i++) block_bytes[i] = 8'(17 * i);
        applyStimulus(2'b00, 1'b0);
        checkIssue(2'b00);
        checkOutput("key128_literal", key_out,
                    {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        checkOutput("block_literal", 256'(block_out),
                    256'(128'h00112233445566778899aabbccddeeff));
        waitDone(3);

        // 256-bit directed load
        applyStimulus(2'b01, 1'b0);
        checkIssue(2'b01);
        checkOutput("accepted_256_literal", 256'(accepted), 256'(48));
        checkOutput("key256_literal", key_out,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        waitDone(10);

        // clear during a 192-bit load while byte 10 is offered
        fillRandom();
        s1 = 1'b1;
        s2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            byte_in = key_bytes[i];
            byte_valid = 1'b1;
            tick();
        end
        byte_in = key_bytes[10];
        clear = 1'b1;
        tick();
        clear = 1'b0;
        byte_valid = 1'b0;
        checkOutput("clear_busy", 256'(busy), 256'(0));
        checkOutput("clear_ready", 256'(byte_ready), 256'(1));
        checkOutput("clear_err", 256'(err), 256'(0));
        checkOutput("clear_key_held", key_out, exp_key);
        checkOutput("clear_nk_held", 256'(nk), 256'(exp_nk));

        // fresh 128-bit load after the abort
        fillRandom();
        applyStimulus(2'b00, 1'b1);
        checkIssue(2'b00);
        waitDone(int'($urandom_range(0, 40)));

        // 192-bit load, done during ISSUE only, then timeout
        fillRandom();
        applyStimulus(2'b10, 1'b1);
        checkIssue(2'b10);
        done = 1'b1;
        tick();
        done = 1'b0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            if (busy !== 1'b1 || err !== 1'b0) busy_ok = 1'b0;
            tick();
        end
        checkOutput("busy_through_timeout", 256'(busy_ok), 256'(1));
        checkOutput("timeout_err", 256'(err), 256'(1));
        checkOutput("timeout_idle", 256'(busy), 256'(0));
        checkOutput("timeout_ready", 256'(byte_ready), 256'(1));
        checkOutput("timeout_key_held", key_out, exp_key);
        tick();
        checkOutput("timeout_err_pulse", 256'(err), 256'(0));

        // randomized loads
        for (int r = 0; r < 4; r++) begin
            case ($urandom_range(0, 2))
                0:       sz = 2'b00;
                1:       sz = 2'b10;
                default: sz = 2'b01;
            endcase
            fillRandom();
            applyStimulus(sz, 1'b1);
            checkIssue(sz);
            waitDone(int'($urandom_range(0, 50)));
        end

        // reset while waiting for done, with every other input active
        fillRandom();
        applyStimulus(2'b01, 1'b1);
        checkIssue(2'b01);
        tick();
        tick();
        tick();
        reset = 1'b1;
        done = 1'b1;
        byte_valid = 1'b1;
        clear = 1'b1;
        tick();
        checkResetValues("reset_in_wait");
        reset = 1'b0;
        done = 1'b0;
        byte_valid = 1'b0;
        clear = 1'b0;
        tick();
        checkOutput("post_reset_busy", 256'(busy), 256'(0));
        checkOutput("post_reset_err", 256'(err), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
